// File: rtl/vga_pkg.sv
// Shared timing presets, display-side bundle type and helpers for the VGA timing generator.
package vga_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_H_POL    = 1'b0;
  localparam bit VGA640_V_POL    = 1'b0;

  // 800x600 @ 72 Hz, 50 MHz pixel clock, both syncs active-high
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 56;
  localparam int VGA800_H_SYNC   = 120;
  localparam int VGA800_H_BP     = 64;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP     = 37;
  localparam int VGA800_V_SYNC   = 6;
  localparam int VGA800_V_BP     = 23;
  localparam bit VGA800_H_POL    = 1'b1;
  localparam bit VGA800_V_POL    = 1'b1;

  // Display-side signals that travel together through the lead delay line.
  typedef struct packed {
    logic blank_n;
    logic hsync;
    logic vsync;
    logic sync_n;
  } disp_t;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Blanked, no-sync levels for the given polarities.
  function automatic disp_t disp_idle(input bit h_pol, input bit v_pol);
    disp_t d;
    d.blank_n = 1'b0;
    d.hsync   = ~h_pol;
    d.vsync   = ~v_pol;
    d.sync_n  = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bus between the timing generator and its consumers (DAC/pixel mux, framebuffer fetch, game logic).
interface vga_timing_gen_if #(
  parameter int CW = 10,
  parameter int RW = 9
);
  logic          pix_en;
  logic          hsync;
  logic          vsync;
  logic          blank_n;
  logic          sync_n;
  logic [CW-1:0] fetch_col;
  logic [RW-1:0] fetch_row;
  logic          fetch_valid;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  pix_en,
    output hsync, vsync, blank_n, sync_n,
    output fetch_col, fetch_row, fetch_valid, line_start, frame_start
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, blank_n, sync_n,
    input  fetch_col, fetch_row, fetch_valid, line_start, frame_start
  );
endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of DEPTH stages; DEPTH=0 is a straight pass-through.
module vga_delay_line #(
  parameter int              WIDTH   = 1,
  parameter int              DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, en};
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every stage is reset, unlike a RAM, so the display sees blanked levels until real data arrives.
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: raster counters, registered fetch stage, and display outputs lagging it by LEAD pixels.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit H_POL    = VGA640_H_POL,
  parameter bit V_POL    = VGA640_V_POL,
  parameter int LEAD     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int CW = $clog2(H_ACTIVE);
  localparam int RW = $clog2(V_ACTIVE);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] COL_MAX = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(V_ACTIVE - 1);
  localparam disp_t         IDLE    = disp_idle(H_POL, V_POL);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      LEAD < 0 || LEAD > 4) begin : g_bad_params
    $error("vga_timing_gen: porch/sync widths must be >= 1 and LEAD in 0..4");
  end

  logic          pix_en;
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;

  logic          vis;
  logic          hs_act;
  logic          vs_act;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;
  disp_t         disp_nxt;

  logic          f_valid;
  logic [CW-1:0] f_col;
  logic [RW-1:0] f_row;
  disp_t         f_disp;
  disp_t         d_disp;
  logic          line_start;
  logic          frame_start;

  assign pix_en = vga.pix_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + VW'(1);
      end else begin
        hc <= hc + HW'(1);
      end
    end
  end

  // Decode of the position the counter currently points at.
  always_comb begin
    // NOTE: every signal is assigned on every pass through this block, so no latch can be inferred.
    vis     = (hc < H_VIS) && (vc < V_VIS);
    hs_act  = (hc >= HS_BEG) && (hc < HS_END);
    vs_act  = (vc >= VS_BEG) && (vc < VS_END);
    col_nxt = (hc < H_VIS) ? hc[CW-1:0] : COL_MAX;
    row_nxt = (vc < V_VIS) ? vc[RW-1:0] : ROW_MAX;
    disp_nxt.blank_n = vis;
    disp_nxt.hsync   = hs_act ? H_POL : ~H_POL;
    disp_nxt.vsync   = vs_act ? V_POL : ~V_POL;
    disp_nxt.sync_n  = ~(hs_act | vs_act);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_valid     <= 1'b0;
      f_col       <= '0;
      f_row       <= '0;
      f_disp      <= IDLE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking, so this stage captures the pre-edge hc/vc that the counter is leaving.
      line_start  <= pix_en && (hc == '0);
      frame_start <= pix_en && (hc == '0) && (vc == '0);
      if (pix_en) begin
        f_valid <= vis;
        f_col   <= col_nxt;
        f_row   <= row_nxt;
        f_disp  <= disp_nxt;
      end
    end
  end

  vga_delay_line #(
    .WIDTH   ($bits(disp_t)),
    .DEPTH   (LEAD),
    .RST_VAL (IDLE)
  ) u_lead (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .d     (f_disp),
    .q     (d_disp)
  );

  assign vga.hsync       = d_disp.hsync;
  assign vga.vsync       = d_disp.vsync;
  assign vga.blank_n     = d_disp.blank_n;
  assign vga.sync_n      = d_disp.sync_n;
  assign vga.fetch_valid = f_valid;
  assign vga.fetch_col   = f_col;
  assign vga.fetch_row   = f_row;
  assign vga.line_start  = line_start;
  assign vga.frame_start = frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised scoreboard bench for vga_timing_gen: small raster against a linear-index model, plus a default-timing line check.
module tb_vga_timing_gen;

  localparam int HA = 8, HFP = 2, HS = 3, HB = 1;
  localparam int VA = 4, VFP = 1, VS = 2, VB = 1;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;
  localparam int N  = HT * VT;
  localparam int LEAD = 2;
  localparam bit H_POL = 1'b0, V_POL = 1'b0;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic       sync_n;
    logic       valid;
    logic [2:0] col;
    logic [1:0] row;
    logic       ls;
    logic       fs;
  } obs_t;

  localparam obs_t RST = '{hsync: ~H_POL, vsync: ~V_POL, blank_n: 1'b0, sync_n: 1'b1,
                           valid: 1'b0, col: 3'd0, row: 2'd0, ls: 1'b0, fs: 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(3), .RW(2))  bus ();
  vga_timing_gen_if #(.CW(10), .RW(9)) bus_def ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .H_POL(H_POL), .V_POL(V_POL), .LEAD(LEAD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (bus)
  );

  vga_timing_gen dut_def (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (bus_def)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   k       = 0;
  obs_t q[$];
  obs_t last    = RST;
  bit   pend    = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.hsync = bus.hsync;   o.vsync = bus.vsync;
    o.blank_n = bus.blank_n; o.sync_n = bus.sync_n;
    o.valid = bus.fetch_valid; o.col = bus.fetch_col; o.row = bus.fetch_row;
    o.ls = bus.line_start; o.fs = bus.frame_start;
    return o;
  endfunction

  // Expected outputs after the k-th pix_en since reset, from the linear raster index.
  function automatic obs_t model(input int kk);
    obs_t o;
    int p, c, r, pd, cd, rd;
    bit hs, vs;
    p = kk % N; c = p % HT; r = p / HT;
    o.valid = (c < HA) && (r < VA);
    o.col   = 3'((c < HA) ? c : HA - 1);
    o.row   = 2'((r < VA) ? r : VA - 1);
    o.ls    = (c == 0);
    o.fs    = (p == 0);
    if (kk >= LEAD) begin
      pd = (kk - LEAD) % N; cd = pd % HT; rd = pd / HT;
      hs = (cd >= HA + HFP) && (cd < HA + HFP + HS);
      vs = (rd >= VA + VFP) && (rd < VA + VFP + VS);
      o.blank_n = (cd < HA) && (rd < VA);
      o.hsync   = hs ? H_POL : ~H_POL;
      o.vsync   = vs ? V_POL : ~V_POL;
      o.sync_n  = ~(hs | vs);
    end else begin
      o.blank_n = RST.blank_n; o.hsync = RST.hsync; o.vsync = RST.vsync; o.sync_n = RST.sync_n;
    end
    return o;
  endfunction

  task automatic step(input bit en);
    @(posedge clk);
    #2;
    bus.pix_en = en;
    if (en && rst_n) begin
      q.push_back(model(k));
      k++;
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 bus.pix_en = 1'b0;
    #1 rst_n = 1'b0;
    k = 0;
    #1 check("async_reset", 32'(sample()), 32'(RST));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: an output update is due in every cycle that follows a sampled pix_en.
  always @(posedge clk) pend = rst_n && bus.pix_en;

  always @(negedge clk) begin
    obs_t e;
    if (!rst_n) begin
      q.delete();
      e = RST;
    end else if (pend) begin
      if (q.size() == 0) begin
        check("sb_queue_nonempty", 32'(q.size()), 32'd1);
        e = last;
      end else begin
        e = q.pop_front();
      end
    end else begin
      e = last;
      e.ls = 1'b0;
      e.fs = 1'b0;
    end
    check("sb_outputs", 32'(sample()), 32'(e));
    last = e;
  end

  initial begin
    int   first_fv, first_bn, last_fall, h_fall, low, run, falls, vs_low;
    logic ph, pb;
    bus.pix_en = 1'b0;
    bus_def.pix_en = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_blank_n", 32'(bus.blank_n), 32'd0);
    check("rst_hsync", 32'(bus.hsync), 32'd1);
    check("rst_vsync", 32'(bus.vsync), 32'd1);
    check("rst_sync_n", 32'(bus.sync_n), 32'd1);
    check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    check("rst_fetch_pos", 32'({bus.fetch_col, bus.fetch_row}), 32'd0);
    check("rst_line_start", 32'(bus.line_start), 32'd0);
    check("rst_frame_start", 32'(bus.frame_start), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Default 640x480 timing, pix_en held high, over four lines.
    h_fall = -1; low = 0; run = 0; falls = 0; vs_low = 0; ph = 1'b1; pb = 1'b0;
    for (int i = 0; i < 3300; i++) begin
      @(negedge clk);
      if (bus_def.hsync === 1'b0) low++;
      if (bus_def.blank_n === 1'b1) run++;
      if (bus_def.vsync !== 1'b1) vs_low++;
      if (ph === 1'b1 && bus_def.hsync === 1'b0) begin
        if (h_fall >= 0) check("def_hsync_period", 32'(i - h_fall), 32'd800);
        h_fall = i;
        falls++;
      end
      if (ph === 1'b0 && bus_def.hsync === 1'b1) begin
        check("def_hsync_low", 32'(low), 32'd96);
        low = 0;
      end
      if (pb === 1'b1 && bus_def.blank_n === 1'b0) begin
        check("def_blank_run", 32'(run), 32'd640);
        run = 0;
      end
      ph = bus_def.hsync;
      pb = bus_def.blank_n;
    end
    check("def_hsync_falls", 32'(falls), 32'd4);
    check("def_vsync_idle", 32'(vs_low), 32'd0);

    // Continuous pix_en over two frames: lead alignment and frame wrap.
    first_fv = -1; first_bn = -1;
    for (int i = 0; i < 2 * N + 4; i++) begin
      step(1'b1);
      if (first_fv < 0 && bus.fetch_valid === 1'b1) first_fv = i;
      if (first_bn < 0 && bus.blank_n === 1'b1) first_bn = i;
    end
    check("lead_alignment", 32'(first_bn - first_fv), 32'(LEAD));

    // pix_en every second clk: hsync period doubles.
    last_fall = -1; ph = bus.hsync;
    for (int i = 0; i < 4 * N; i++) begin
      step(i[0] == 1'b0);
      if (ph === 1'b1 && bus.hsync === 1'b0) begin
        if (last_fall >= 0) check("hsync_period_half_rate", 32'(i - last_fall), 32'd28);
        last_fall = i;
      end
      ph = bus.hsync;
    end

    for (int i = 0; i < 500; i++) step(1'($urandom_range(0, 1)));

    // Abort mid-frame, reach hc=5 vc=2 from a clean start, then abort again there.
    mid_reset();
    for (int i = 0; i < 1000 && k < 2 * HT + 5; i++) step(1'($urandom_range(0, 1)));
    check("reach_hc5_vc2", 32'(k), 32'(2 * HT + 5));
    mid_reset();
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 3) != 0));

    repeat (3) step(1'b0);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
